epl_tx_scheduler: RTL and testbench

EPL_TX_SCHEDULER -- requirements
Module: epl_tx_scheduler

---
 rtl/epl_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_epl_tx_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/epl_tx_scheduler.sv
// Frame transmit scheduler: fixed-priority SoC/iso/async arbitration, per-frame timeout
// supervision and inter-frame gap enforcement.
module epl_tx_scheduler #(
    parameter int unsigned IFG_CYCLES = 44,
    parameter int unsigned TX_TIMEOUT = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soc_req,
    input  logic       iso_req,
    input  logic       async_req,
    input  logic       async_en,
    input  logic       tx_done,
    input  logic       err_clr,
    output logic       tx_start,
    output logic [1:0] tx_sel,
    output logic       ack_soc,
    output logic       ack_iso,
    output logic       ack_async,
    output logic       busy,
    output logic       tx_abort,
    output logic       timeout_err,
    output logic       soc_late
);

    localparam int unsigned CntMax = (IFG_CYCLES > TX_TIMEOUT) ? IFG_CYCLES : TX_TIMEOUT;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TX_TIMEOUT);
    localparam logic [CntW-1:0] IfgCnt     = CntW'(IFG_CYCLES);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    localparam logic [1:0] SelNone  = 2'b00;
    localparam logic [1:0] SelSoc   = 2'b01;
    localparam logic [1:0] SelIso   = 2'b10;
    localparam logic [1:0] SelAsync = 2'b11;

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            start_q, start_d;
    logic            ack_soc_q, ack_soc_d;
    logic            ack_iso_q, ack_iso_d;
    logic            ack_async_q, ack_async_d;
    logic            abort_q, abort_d;
    logic            err_q, err_d;
    logic            late_q, late_d;
    logic            soc_prev_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        start_d     = 1'b0;
        ack_soc_d   = 1'b0;
        ack_iso_d   = 1'b0;
        ack_async_d = 1'b0;
        abort_d     = 1'b0;
        late_d      = soc_req && !soc_prev_q && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                sel_d = SelNone;
                cnt_d = '0;
                if (soc_req || iso_req || (async_req && async_en)) begin
                    state_d = StBusy;
                    start_d = 1'b1;
                    cnt_d   = CntOne;
                    if (soc_req)      sel_d = SelSoc;
                    else if (iso_req) sel_d = SelIso;
                    else              sel_d = SelAsync;
                end
            end
            StBusy: begin
                // tx_done wins over a timeout landing on the same cycle
                if (tx_done || (cnt_q == TimeoutCnt)) begin
                    if (tx_done) begin
                        ack_soc_d   = (sel_q == SelSoc);
                        ack_iso_d   = (sel_q == SelIso);
                        ack_async_d = (sel_q == SelAsync);
                    end else begin
                        abort_d = 1'b1;
                    end
                    if (IFG_CYCLES == 0) begin
                        state_d = StIdle;
                        sel_d   = SelNone;
                        cnt_d   = '0;
                    end else begin
                        state_d = StGap;
                        cnt_d   = CntOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StGap: begin
                if (cnt_q == IfgCnt) begin
                    state_d = StIdle;
                    sel_d   = SelNone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = SelNone;
                cnt_d   = '0;
            end
        endcase

        err_d = (err_q && !err_clr) || abort_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= SelNone;
            start_q     <= 1'b0;
            ack_soc_q   <= 1'b0;
            ack_iso_q   <= 1'b0;
            ack_async_q <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            late_q      <= 1'b0;
            soc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            ack_soc_q   <= ack_soc_d;
            ack_iso_q   <= ack_iso_d;
            ack_async_q <= ack_async_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            late_q      <= late_d;
            soc_prev_q  <= soc_req;
        end
    end

    assign tx_start    = start_q;
    assign tx_sel      = sel_q;
    assign ack_soc     = ack_soc_q;
    assign ack_iso     = ack_iso_q;
    assign ack_async   = ack_async_q;
    assign busy        = (state_q != StIdle);
    assign tx_abort    = abort_q;
    assign timeout_err = err_q;
    assign soc_late    = late_q;

endmodule

// File: tb/tb_epl_tx_scheduler.sv
// Directed bench for epl_tx_scheduler (IFG 44, timeout shortened to 20 cycles).
module tb_epl_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       soc_req, iso_req, async_req, async_en, tx_done, err_clr;
    logic       tx_start, ack_soc, ack_iso, ack_async, busy, tx_abort, timeout_err, soc_late;
    logic [1:0] tx_sel;

    int vectors = 0;
    int errors  = 0;
    logic seen_start;

    epl_tx_scheduler #(
        .IFG_CYCLES(44),
        .TX_TIMEOUT(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soc_req    (soc_req),
        .iso_req    (iso_req),
        .async_req  (async_req),
        .async_en   (async_en),
        .tx_done    (tx_done),
        .err_clr    (err_clr),
        .tx_start   (tx_start),
        .tx_sel     (tx_sel),
        .ack_soc    (ack_soc),
        .ack_iso    (ack_iso),
        .ack_async  (ack_async),
        .busy       (busy),
        .tx_abort   (tx_abort),
        .timeout_err(timeout_err),
        .soc_late   (soc_late)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed snapshot: {tx_start, tx_sel, ack_soc, ack_iso, ack_async, busy, abort, err, late}
    function automatic logic [9:0] outs();
        return {tx_start, tx_sel, ack_soc, ack_iso, ack_async, busy, tx_abort, timeout_err,
                soc_late};
    endfunction

    initial begin
        rst = 1'b1;
        {soc_req, iso_req, async_req, async_en, tx_done, err_clr} = '0;
        tick();
        tick();
        check("reset_outputs", 32'(outs()), 32'h0);
        rst = 1'b0;

        // All sources pending: SoC wins, then iso after the 44-cycle gap
        {soc_req, iso_req, async_req, async_en} = 4'b1111;
        tick();
        check("soc_start", 32'(outs()), 32'b1_01_000_1_000);
        soc_req = 1'b0;
        async_req = 1'b0;
        async_en = 1'b0;
        tick();
        check("soc_start_pulse_once", 32'(tx_start), 32'd0);
        check("soc_sel_hold", 32'(tx_sel), 32'd1);
        repeat (8) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("ack_soc", 32'(outs()), 32'b0_01_100_1_000);
        tick();
        check("ack_soc_pulse_once", 32'(ack_soc), 32'd0);
        repeat (42) tick();
        check("gap_last_cycle", 32'(outs()), 32'b0_01_000_1_000);
        tick();
        check("idle_after_gap", 32'(outs()), 32'h0);
        tick();
        check("iso_start", 32'(outs()), 32'b1_10_000_1_000);
        iso_req = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("ack_iso", 32'(outs()), 32'b0_10_010_1_000);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("tx_done_in_gap_ignored", 32'(outs()), 32'b0_10_000_1_000);
        repeat (41) tick();
        tick();
        check("idle_after_iso", 32'(busy), 32'd0);

        // Async gated by async_en
        async_req = 1'b1;
        seen_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_start |= tx_start | busy;
        end
        check("async_blocked", 32'(seen_start), 32'd0);
        async_en = 1'b1;
        tick();
        check("async_start", 32'(outs()), 32'b1_11_000_1_000);
        async_req = 1'b0;
        async_en = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("ack_async", 32'(outs()), 32'b0_11_001_1_000);
        repeat (44) tick();
        check("idle_after_async", 32'(outs()), 32'h0);

        // Timeout without tx_done
        iso_req = 1'b1;
        tick();
        iso_req = 1'b0;
        repeat (19) tick();
        check("busy_at_count_20", 32'(outs()), 32'b0_10_000_1_000);
        tick();
        check("timeout_abort", 32'(outs()), 32'b0_10_000_1_110);
        tick();
        check("timeout_sticky", 32'(outs()), 32'b0_10_000_1_010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);
        repeat (41) tick();
        tick();
        check("idle_after_timeout", 32'(outs()), 32'h0);

        // tx_done on the timeout cycle completes normally
        iso_req = 1'b1;
        tick();
        iso_req = 1'b0;
        repeat (19) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_beats_timeout", 32'(outs()), 32'b0_10_010_1_000);
        repeat (44) tick();
        check("idle_after_race", 32'(busy), 32'd0);

        // SoC arriving mid-frame: flagged late, not pre-empting
        iso_req = 1'b1;
        tick();
        iso_req = 1'b0;
        tick();
        soc_req = 1'b1;
        tick();
        check("soc_late", 32'(outs()), 32'b0_10_000_1_001);
        tick();
        check("soc_late_pulse_once", 32'(soc_late), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("iso_completes", 32'(ack_iso), 32'd1);
        repeat (43) tick();
        check("no_preempt_in_gap", 32'(outs()), 32'b0_10_000_1_000);
        tick();
        check("idle_before_soc", 32'(busy), 32'd0);
        tick();
        check("late_soc_start", 32'(outs()), 32'b1_01_000_1_000);
        soc_req = 1'b0;

        // Reset mid-BUSY, then stray tx_done
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_mid_busy", 32'(outs()), 32'h0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_done_after_reset", 32'(outs()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
